bp_btb: RTL and testbench
=========================

Name: bp_btb

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters, queried by the IF stage each cycle.
- Lets the pipeline redirect fetch on a predicted-taken branch instead of flushing IF/ID and ID/EX on every taken branch resolved in EX.
- Lookup is combinational on the fetch PC. Training comes from the EX-stage branch unit. Table state, counters and perf statistics are sequential.

Parameters:
- PC_W, 9, program counter width.
- ENTRIES, 16, table depth; must be a power of two, at least 2.
- CTR_W, 2, direction counter width.
- CNT_W, 16, width of the performance counters.
- Derived localparam IDX_W = $clog2(ENTRIES); TAG_W = PC_W-IDX_W-2, which must be at least 1.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_pc  in  PC_W  fetch PC to look up
- pred_hit  out  1  valid entry with matching tag found for if_pc
- pred_taken  out  1  pred_hit and counter MSB set
- pred_target  out  PC_W  stored target on hit, else if_pc+4
- upd_valid  in  1  EX stage resolved a branch/jump this cycle
- upd_pc  in  PC_W  PC of the resolved instruction
- upd_taken  in  1  actual outcome
- upd_target  in  PC_W  actual target
- upd_mispred  in  1  EX detected misprediction; qualified by upd_valid
- flush_all  in  1  synchronous invalidate of the whole table
- stat_branches  out  CNT_W  count of upd_valid cycles
- stat_mispreds  out  CNT_W  count of upd_valid&&upd_mispred cycles

Behaviour:
- Address split: index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] is ignored.
- Entry fields: valid, tag[TAG_W], target[PC_W], ctr[CTR_W].
- Reset (reset=0, asynchronous):
  - all valid=0, all ctr=0, all targets and tags=0.
  - stat_branches=0, stat_mispreds=0.
  - Outputs therefore read pred_hit=0, pred_taken=0, pred_target=if_pc+4.
  - Reset asserted mid-operation discards any update in flight.
- Lookup:
  - Purely combinational, zero latency.
  - pred_target addition wraps modulo 2^PC_W.
- Update (rising edge when upd_valid=1, flush_all=0), with entry at index(upd_pc):
  - Hit (valid and tag match), taken: ctr saturating increment to 2^CTR_W-1; target<=upd_target.
  - Hit, not taken: ctr saturating decrement to 0; target unchanged.
  - Miss (invalid, or tag mismatch), taken: allocate/replace. valid<=1, tag, target<=upd_target, ctr<=2^(CTR_W-1) (weakly taken).
  - Miss, not taken: no change; never allocate.
- Same-cycle lookup and update to the same index: lookup returns pre-update state. The new state is visible the next cycle.
- flush_all=1: all valid<=0 on the next edge; ctr, tag and target are not cleared. Flush wins over a simultaneous update, which is dropped. Stats still count the update and are not cleared by flush.
- Stats:
  - stat_branches += 1 per upd_valid cycle.
  - stat_mispreds += 1 per upd_valid&&upd_mispred cycle.
  - Both saturate at 2^CNT_W-1; no wrap.
- upd_mispred with upd_valid=0 is ignored.

Decomposition:
- Shared package (alongside Pipe_Buf_Reg_PKG) holds typedef struct btb_entry_t {valid, tag, target, ctr} and a function for saturating counter increment/decrement.
- One sub-module is natural: sat_counter, parametrised by width, with inc/dec/load inputs. It is used for the per-entry direction counters and for both stat counters with dec tied off.
- The table itself stays a flop array of btb_entry_t in bp_btb, not a memory macro, for asynchronous reset.

Test Plan (defaults PC_W=9, ENTRIES=16, CTR_W=2):
1. Reset, then if_pc=0x024 -> pred_hit=0, pred_taken=0, pred_target=0x028; stats 0.
2. Update pc=0x024 taken target=0x010, lookup 0x024 same cycle and next cycle:
   - same cycle -> hit=0.
   - next cycle -> hit=1, taken=1, target=0x010, ctr=2.
3. Counter walk on 0x024: two not-taken updates -> ctr 1 then 0, pred_taken=0 while hit=1. A third not-taken update -> ctr stays 0. Four taken updates -> ctr 1,2,3,3; pred_taken=1 from ctr=2.
4. Alias test: with 0x024 resident, lookup 0x064 (same index 9, tag 1 vs 0):
   - lookup -> hit=0.
   - not-taken update of 0x064 -> no change; 0x024 still hits.
   - taken update of 0x064 target=0x100 -> 0x064 hits with ctr=2, and 0x024 now misses.
5. Flush vs update: flush_all=1 in the same cycle as a taken update to 0x0A0 -> next cycle every lookup misses, including 0x0A0; stat_branches incremented by 1.
6. Stats saturation (CNT_W=4 override): 20 cycles of upd_valid=1, upd_mispred=1 -> both stats read 15. Async reset pulse mid-burst -> both stats 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/bp_btb_pkg.sv
// Shared definitions for the branch target buffer: default geometry and
// the saturating step used by every counter in the block.
package bp_btb_pkg;

    localparam int BTB_PC_W    = 9;
    localparam int BTB_ENTRIES = 16;
    localparam int BTB_CTR_W   = 2;
    localparam int BTB_CNT_W   = 16;

    // Saturating +1 / -1 on a value that is 'width' bits wide (width <= 32).
    // inc and dec together cancel out, so the value is held.
    function automatic logic [31:0] sat_step(input logic [31:0] value,
                                             input logic        inc,
                                             input logic        dec,
                                             input int unsigned width);
        logic [32:0] max_val;
        max_val  = (33'd1 << width) - 33'd1;
        sat_step = value;
        if (inc && !dec) begin
            if ({1'b0, value} != max_val) begin
                sat_step = value + 32'd1;
            end
        end else if (dec && !inc) begin
            if (value != 32'd0) begin
                sat_step = value - 32'd1;
            end
        end
    endfunction

endpackage

// File: rtl/bp_btb_sat_counter.sv
// Width-parametrised saturating counter with load. Load has priority over
// inc/dec. Used for the per-entry direction counters and the perf counters.
module bp_btb_sat_counter
    import bp_btb_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value
);

    logic [W-1:0] value_reg;
    logic [W-1:0] value_next;

    // Next value: load wins, otherwise a saturating step.
    always_comb begin
        value_next = value_reg;
        if (load) begin
            value_next = load_val;
        end else begin
            value_next = W'(sat_step(32'(value_reg), inc, dec, W));
        end
    end

    // Counter state, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_reg <= '0;
        end else begin
            value_reg <= value_next;
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Combinational lookup for IF, training from EX, plus branch and
// misprediction statistics.
module bp_btb
    import bp_btb_pkg::*;
#(
    parameter int PC_W    = BTB_PC_W,
    parameter int ENTRIES = BTB_ENTRIES,
    parameter int CTR_W   = BTB_CTR_W,
    parameter int CNT_W   = BTB_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  if_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic             upd_mispred,
    input  logic             flush_all,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispreds
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;
    // Freshly allocated entries start weakly taken.
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

    // Entry layout depends on the instance geometry, so it is declared here.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [CTR_W-1:0] ctr;
    } btb_entry_t;

    btb_entry_t [ENTRIES-1:0] table_q;

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    btb_entry_t       if_entry;
    btb_entry_t       upd_entry;
    logic             upd_en;
    logic             upd_hit;
    logic             upd_alloc;
    logic             upd_train;
    logic             unused_pc_lsbs;

    assign if_idx  = if_pc[IDX_W+1:2];
    assign if_tag  = if_pc[PC_W-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[PC_W-1:IDX_W+2];

    // Instructions are word aligned; the low PC bits carry no information.
    assign unused_pc_lsbs = &{1'b0, if_pc[1:0], upd_pc[1:0]};

    // Lookup sees the pre-update table; writes land on the next edge.
    assign if_entry    = table_q[if_idx];
    assign pred_hit    = if_entry.valid && (if_entry.tag == if_tag);
    assign pred_taken  = pred_hit && if_entry.ctr[CTR_W-1];
    assign pred_target = pred_hit ? if_entry.target : (if_pc + PC_W'(4));

    // A flush drops any simultaneous training.
    assign upd_en    = upd_valid && !flush_all;
    assign upd_entry = table_q[upd_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);
    assign upd_alloc = upd_en && upd_taken && !upd_hit;
    assign upd_train = upd_en && upd_hit;

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             sel;
            logic             valid_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [PC_W-1:0]  target_reg;
            logic [CTR_W-1:0] ctr_q;

            assign sel = (upd_idx == IDX_W'(gi));

            // Entry fields: flush clears valid only; allocate writes all,
            // a taken hit refreshes the target.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                end else if (flush_all) begin
                    valid_reg  <= 1'b0;
                end else if (sel && upd_alloc) begin
                    valid_reg  <= 1'b1;
                    tag_reg    <= upd_tag;
                    target_reg <= upd_target;
                end else if (sel && upd_train && upd_taken) begin
                    target_reg <= upd_target;
                end
            end

            bp_btb_sat_counter #(.W(CTR_W)) u_ctr (
                .clk      (clk),
                .reset    (reset),
                .inc      (sel && upd_train && upd_taken),
                .dec      (sel && upd_train && !upd_taken),
                .load     (sel && upd_alloc),
                .load_val (CTR_WEAK),
                .value    (ctr_q)
            );

            assign table_q[gi] = '{valid: valid_reg, tag: tag_reg,
                                   target: target_reg, ctr: ctr_q};
        end
    endgenerate

    bp_btb_sat_counter #(.W(CNT_W)) u_stat_branches (
        .clk      (clk),
        .reset    (reset),
        .inc      (upd_valid),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .value    (stat_branches)
    );

    bp_btb_sat_counter #(.W(CNT_W)) u_stat_mispreds (
        .clk      (clk),
        .reset    (reset),
        .inc      (upd_valid && upd_mispred),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .value    (stat_mispreds)
    );

endmodule

// File: tb/tb_bp_btb.sv
// Directed bench for bp_btb: a default-width instance and a CNT_W=4
// instance share all stimulus; the narrow one exercises stat saturation.
module tb_bp_btb;

    localparam int PC_W = 9;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [PC_W-1:0] if_pc = '0;
    logic            upd_valid = 1'b0;
    logic [PC_W-1:0] upd_pc = '0;
    logic            upd_taken = 1'b0;
    logic [PC_W-1:0] upd_target = '0;
    logic            upd_mispred = 1'b0;
    logic            flush_all = 1'b0;

    logic            pred_hit, pred_taken;
    logic [PC_W-1:0] pred_target;
    logic [15:0]     stat_branches, stat_mispreds;

    logic            s_pred_hit, s_pred_taken;
    logic [PC_W-1:0] s_pred_target;
    logic [3:0]      s_stat_branches, s_stat_mispreds;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_br = 0;
    int exp_mp = 0;

    always #5 clk = ~clk;

    bp_btb dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispred(upd_mispred), .flush_all(flush_all),
        .stat_branches(stat_branches), .stat_mispreds(stat_mispreds)
    );

    bp_btb #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_hit(s_pred_hit), .pred_taken(s_pred_taken), .pred_target(s_pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispred(upd_mispred), .flush_all(flush_all),
        .stat_branches(s_stat_branches), .stat_mispreds(s_stat_mispreds)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply if_pc and check both instances' prediction outputs.
    task automatic look(input string tag, input logic [PC_W-1:0] pc,
                        input logic hit, input logic taken, input logic [PC_W-1:0] tgt);
        if_pc = pc;
        #1;
        $display("lookup %-12s pc=0x%03h hit=%0b taken=%0b target=0x%03h",
                 tag, pc, pred_hit, pred_taken, pred_target);
        chk({tag, ".hit"}, 32'(pred_hit), 32'(hit));
        chk({tag, ".taken"}, 32'(pred_taken), 32'(taken));
        chk({tag, ".target"}, 32'(pred_target), 32'(tgt));
        chk({tag, ".s_hit"}, 32'(s_pred_hit), 32'(hit));
    endtask

    // One-cycle training update, inputs held across exactly one rising edge.
    task automatic update(input logic [PC_W-1:0] pc, input logic taken,
                          input logic [PC_W-1:0] tgt, input logic mp);
        upd_valid   = 1'b1;
        upd_pc      = pc;
        upd_taken   = taken;
        upd_target  = tgt;
        upd_mispred = mp;
        @(posedge clk);
        #1;
        upd_valid   = 1'b0;
        upd_mispred = 1'b0;
        exp_br++;
        if (mp) exp_mp++;
        $display("update pc=0x%03h taken=%0b target=0x%03h mispred=%0b", pc, taken, tgt, mp);
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, ".branches"}, 32'(stat_branches), 32'(exp_br));
        chk({tag, ".mispreds"}, 32'(stat_mispreds), 32'(exp_mp));
    endtask

    initial begin
        // 1. Reset state
        look("rst", 9'h024, 1'b0, 1'b0, 9'h028);
        look("rst_wrap", 9'h1FC, 1'b0, 1'b0, 9'h000);
        chk_stats("rst");
        chk("rst.s_branches", 32'(s_stat_branches), 32'd0);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // 2. Allocate 0x024; same-cycle lookup still sees the old state
        upd_valid = 1'b1; upd_pc = 9'h024; upd_taken = 1'b1; upd_target = 9'h010;
        look("same_cyc", 9'h024, 1'b0, 1'b0, 9'h028);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        exp_br++;
        look("alloc", 9'h024, 1'b1, 1'b1, 9'h010);
        chk_stats("alloc");

        // 3. Counter walk: 2 -> 1 -> 0 -> 0 -> 1 -> 2 -> 3 -> 3 -> 2 -> 1
        update(9'h024, 1'b0, 9'h1F0, 1'b1);
        look("ctr1", 9'h024, 1'b1, 1'b0, 9'h010);
        update(9'h024, 1'b0, 9'h1F0, 1'b0);
        look("ctr0", 9'h024, 1'b1, 1'b0, 9'h010);
        update(9'h024, 1'b0, 9'h1F0, 1'b0);
        update(9'h024, 1'b1, 9'h010, 1'b1);
        look("ctr0_sat", 9'h024, 1'b1, 1'b0, 9'h010);
        update(9'h024, 1'b1, 9'h010, 1'b0);
        look("ctr2", 9'h024, 1'b1, 1'b1, 9'h010);
        update(9'h024, 1'b1, 9'h010, 1'b0);
        update(9'h024, 1'b1, 9'h010, 1'b0);
        look("ctr3_sat", 9'h024, 1'b1, 1'b1, 9'h010);
        update(9'h024, 1'b0, 9'h1F0, 1'b1);
        look("ctr3_down", 9'h024, 1'b1, 1'b1, 9'h010);
        update(9'h024, 1'b0, 9'h1F0, 1'b0);
        look("ctr1_again", 9'h024, 1'b1, 1'b0, 9'h010);
        update(9'h024, 1'b1, 9'h010, 1'b0);
        chk_stats("walk");

        // 4. Alias at index 9: 0x064 (tag 1) vs resident 0x024 (tag 0)
        look("alias_miss", 9'h064, 1'b0, 1'b0, 9'h068);
        update(9'h064, 1'b0, 9'h100, 1'b0);
        look("alias_nt", 9'h064, 1'b0, 1'b0, 9'h068);
        look("orig_kept", 9'h024, 1'b1, 1'b1, 9'h010);
        update(9'h064, 1'b1, 9'h100, 1'b1);
        look("alias_alloc", 9'h064, 1'b1, 1'b1, 9'h100);
        look("orig_evict", 9'h024, 1'b0, 1'b0, 9'h028);
        update(9'h064, 1'b0, 9'h000, 1'b0);
        look("alias_ctr1", 9'h064, 1'b1, 1'b0, 9'h100);

        // 5. Flush beats a simultaneous allocate; stats still count
        flush_all = 1'b1;
        update(9'h0A0, 1'b1, 9'h040, 1'b0);
        flush_all = 1'b0;
        look("flush_a0", 9'h0A0, 1'b0, 1'b0, 9'h0A4);
        look("flush_64", 9'h064, 1'b0, 1'b0, 9'h068);
        chk_stats("flush");

        // 6. Stat saturation on the CNT_W=4 instance, then async reset mid-burst
        reset = 1'b0;
        #1;
        chk("rst2.s_branches", 32'(s_stat_branches), 32'd0);
        reset = 1'b1;
        exp_br = 0;
        exp_mp = 0;
        upd_valid = 1'b1; upd_mispred = 1'b1; upd_pc = 9'h1F0; upd_taken = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            exp_br++;
            exp_mp++;
        end
        $display("burst of 20: s_branches=%0d s_mispreds=%0d", s_stat_branches, s_stat_mispreds);
        chk("sat.s_branches", 32'(s_stat_branches), 32'd15);
        chk("sat.s_mispreds", 32'(s_stat_mispreds), 32'd15);
        chk_stats("sat_wide");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        $display("async reset mid-burst: s_branches=%0d branches=%0d", s_stat_branches, stat_branches);
        chk("arst.s_branches", 32'(s_stat_branches), 32'd0);
        chk("arst.s_mispreds", 32'(s_stat_mispreds), 32'd0);
        chk("arst.branches", 32'(stat_branches), 32'd0);
        chk("arst.mispreds", 32'(stat_mispreds), 32'd0);
        upd_valid = 1'b0;
        upd_mispred = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
